// File: rtl/sram_axi_bridge_np.sv
// NPORT SRAM-like masters onto one AXI3 master with round-robin read/write arbitration.
// Define SAXI_RAW_ADDR_CMP_EN to block reads only on a same-word pending write.
module sram_axi_bridge_np #(
  parameter int NPORT    = 2,
  parameter int RD_DEPTH = 2
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic [NPORT-1:0]      sram_req,
  input  logic [NPORT-1:0]      sram_wr,
  input  logic [2*NPORT-1:0]    sram_size,
  input  logic [4*NPORT-1:0]    sram_wstrb,
  input  logic [32*NPORT-1:0]   sram_addr,
  input  logic [32*NPORT-1:0]   sram_wdata,
  output logic [NPORT-1:0]      sram_addr_ok,
  output logic [NPORT-1:0]      sram_data_ok,
  output logic [32*NPORT-1:0]   sram_rdata,
  output logic [3:0]            arid,
  output logic [31:0]           araddr,
  output logic [7:0]            arlen,
  output logic [2:0]            arsize,
  output logic [1:0]            arburst,
  output logic [1:0]            arlock,
  output logic [3:0]            arcache,
  output logic [2:0]            arprot,
  output logic                  arvalid,
  input  logic                  arready,
  input  logic [3:0]            rid,
  input  logic [31:0]           rdata,
  input  logic [1:0]            rresp,
  input  logic                  rlast,
  input  logic                  rvalid,
  output logic                  rready,
  output logic [3:0]            awid,
  output logic [31:0]           awaddr,
  output logic [7:0]            awlen,
  output logic [2:0]            awsize,
  output logic [1:0]            awburst,
  output logic [1:0]            awlock,
  output logic [3:0]            awcache,
  output logic [2:0]            awprot,
  output logic                  awvalid,
  input  logic                  awready,
  output logic [3:0]            wid,
  output logic [31:0]           wdata,
  output logic [3:0]            wstrb,
  output logic                  wlast,
  output logic                  wvalid,
  input  logic                  wready,
  input  logic [3:0]            bid,
  input  logic [1:0]            bresp,
  input  logic                  bvalid,
  output logic                  bready
);

  localparam int PW = (NPORT > 1) ? $clog2(NPORT) : 1;
  localparam int CW = $clog2(RD_DEPTH + 1);

  typedef enum logic {AR_IDLE, AR_REQ} ar_state_t;
  typedef enum logic [1:0] {W_IDLE, W_SEND, W_RESP} w_state_t;

  ar_state_t ar_state, ar_next;
  w_state_t  w_state, w_next;

  logic [PW-1:0]    rd_ptr, wr_ptr, rd_sel, wr_sel, ar_id, w_id;
  logic [CW-1:0]    rd_cnt [NPORT];
  logic [NPORT-1:0] rd_elig, wr_elig, rd_gnt, wr_gnt;
  logic             rd_any, wr_any, w_busy, raw;
  logic [31:0]      ar_addr, w_addr, w_data;
  logic [1:0]       ar_size, w_size;
  logic [3:0]       w_strb;
  logic             aw_pend, w_pend;
  logic             unused_ok;

  assign w_busy    = (w_state != W_IDLE);
  assign unused_ok = ^{rresp, bresp, rlast};

  always_comb begin
    rd_elig = '0;
    wr_elig = '0;
    raw     = 1'b0;
    for (int p = 0; p < NPORT; p++) begin
`ifdef SAXI_RAW_ADDR_CMP_EN
      raw = w_busy && (w_addr[31:2] == sram_addr[32*p+2 +: 30]);
`else
      raw = w_busy;
`endif
      rd_elig[p] = sram_req[p] && !sram_wr[p] && (ar_state == AR_IDLE) &&
                   (rd_cnt[p] < CW'(RD_DEPTH)) && !(w_busy && w_id == PW'(p)) && !raw;
      // A port with reads in flight may not write, so its responses stay in order.
      wr_elig[p] = sram_req[p] && sram_wr[p] && !w_busy && (rd_cnt[p] == '0);
    end
  end

  // Descending offset scan so the port closest to the pointer wins.
  always_comb begin
    rd_any = 1'b0;
    wr_any = 1'b0;
    rd_sel = rd_ptr;
    wr_sel = wr_ptr;
    rd_gnt = '0;
    wr_gnt = '0;
    for (int i = NPORT - 1; i >= 0; i--) begin
      if (rd_elig[(int'(rd_ptr) + i) % NPORT]) begin
        rd_any = 1'b1;
        rd_sel = PW'((int'(rd_ptr) + i) % NPORT);
      end
      if (wr_elig[(int'(wr_ptr) + i) % NPORT]) begin
        wr_any = 1'b1;
        wr_sel = PW'((int'(wr_ptr) + i) % NPORT);
      end
    end
    if (rd_any) rd_gnt[rd_sel] = 1'b1;
    if (wr_any) wr_gnt[wr_sel] = 1'b1;
  end

  always_comb begin
    ar_next = ar_state;
    w_next  = w_state;
    case (ar_state)
      AR_IDLE: if (rd_any)  ar_next = AR_REQ;
      AR_REQ:  if (arready) ar_next = AR_IDLE;
      default: ar_next = AR_IDLE;
    endcase
    case (w_state)
      W_IDLE: if (wr_any) w_next = W_SEND;
      W_SEND: if ((!aw_pend || awready) && (!w_pend || wready)) w_next = W_RESP;
      W_RESP: if (bvalid) w_next = W_IDLE;
      default: w_next = W_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      ar_state <= AR_IDLE;
      w_state  <= W_IDLE;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      for (int p = 0; p < NPORT; p++) rd_cnt[p] <= '0;
    end else begin
      ar_state <= ar_next;
      w_state  <= w_next;
      if (rd_any) rd_ptr <= PW'((int'(rd_sel) + 1) % NPORT);
      if (wr_any) wr_ptr <= PW'((int'(wr_sel) + 1) % NPORT);
      for (int p = 0; p < NPORT; p++) begin
        if (rd_gnt[p] && !(rvalid && rid == 4'(p)))
          rd_cnt[p] <= rd_cnt[p] + CW'(1);
        else if (!rd_gnt[p] && rvalid && rid == 4'(p))
          rd_cnt[p] <= rd_cnt[p] - CW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      ar_addr <= '0;
      ar_size <= '0;
      ar_id   <= '0;
      w_addr  <= '0;
      w_size  <= '0;
      w_strb  <= '0;
      w_data  <= '0;
      w_id    <= '0;
      aw_pend <= 1'b0;
      w_pend  <= 1'b0;
    end else begin
      if (rd_any) begin
        ar_addr <= sram_addr[32*rd_sel +: 32];
        ar_size <= sram_size[2*rd_sel +: 2];
        ar_id   <= rd_sel;
      end
      if (wr_any) begin
        w_addr  <= sram_addr[32*wr_sel +: 32];
        w_size  <= sram_size[2*wr_sel +: 2];
        w_strb  <= sram_wstrb[4*wr_sel +: 4];
        w_data  <= sram_wdata[32*wr_sel +: 32];
        w_id    <= wr_sel;
        aw_pend <= 1'b1;
        w_pend  <= 1'b1;
      end else begin
        if (aw_pend && awready) aw_pend <= 1'b0;
        if (w_pend && wready)   w_pend  <= 1'b0;
      end
    end
  end

  always_comb begin
    sram_data_ok = '0;
    for (int p = 0; p < NPORT; p++)
      sram_data_ok[p] = resetn && ((rvalid && rid == 4'(p)) ||
                                   (w_state == W_RESP && bvalid && bid == 4'(p)));
  end

  assign sram_addr_ok = (rd_gnt | wr_gnt) & {NPORT{resetn}};
  assign sram_rdata   = {NPORT{rdata}};

  assign arid    = 4'(ar_id);
  assign araddr  = ar_addr;
  assign arlen   = 8'd0;
  assign arsize  = {1'b0, ar_size};
  assign arburst = 2'b01;
  assign arlock  = 2'b00;
  assign arcache = 4'd0;
  assign arprot  = 3'd0;
  assign arvalid = (ar_state == AR_REQ);
  assign rready  = 1'b1;

  assign awid    = 4'(w_id);
  assign awaddr  = w_addr;
  assign awlen   = 8'd0;
  assign awsize  = {1'b0, w_size};
  assign awburst = 2'b01;
  assign awlock  = 2'b00;
  assign awcache = 4'd0;
  assign awprot  = 3'd0;
  assign awvalid = aw_pend;
  assign wid     = 4'(w_id);
  assign wdata   = w_data;
  assign wstrb   = w_strb;
  assign wlast   = 1'b1;
  assign wvalid  = w_pend;
  assign bready  = 1'b1;

endmodule

// File: tb/tb_sram_axi_bridge_np.sv
// Directed bench for sram_axi_bridge_np (NPORT=2, RD_DEPTH=2) with a hand-driven AXI slave.
module tb_sram_axi_bridge_np;

`ifdef SAXI_RAW_ADDR_CMP_EN
  localparam bit RAW_CMP = 1'b1;
`else
  localparam bit RAW_CMP = 1'b0;
`endif

  logic        clk, resetn;
  logic [1:0]  sram_req, sram_wr, sram_addr_ok, sram_data_ok;
  logic [3:0]  sram_size;
  logic [7:0]  sram_wstrb;
  logic [63:0] sram_addr, sram_wdata, sram_rdata;
  logic [3:0]  arid, arcache, rid, awid, awcache, wid, wstrb, bid;
  logic [31:0] araddr, rdata, awaddr, wdata;
  logic [7:0]  arlen, awlen;
  logic [2:0]  arsize, arprot, awsize, awprot;
  logic [1:0]  arburst, arlock, rresp, awburst, awlock, bresp;
  logic        arvalid, arready, rlast, rvalid, rready;
  logic        awvalid, awready, wlast, wvalid, wready, bvalid, bready;

  int checks = 0;
  int errors = 0;
  logic [19:0] rr_pattern;
  logic [3:0]  drain_ids;

  sram_axi_bridge_np #(.NPORT(2), .RD_DEPTH(2)) dut (
    .clk(clk), .resetn(resetn),
    .sram_req(sram_req), .sram_wr(sram_wr), .sram_size(sram_size),
    .sram_wstrb(sram_wstrb), .sram_addr(sram_addr), .sram_wdata(sram_wdata),
    .sram_addr_ok(sram_addr_ok), .sram_data_ok(sram_data_ok), .sram_rdata(sram_rdata),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arlock(arlock), .arcache(arcache), .arprot(arprot), .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
    .awlock(awlock), .awcache(awcache), .awprot(awprot), .awvalid(awvalid), .awready(awready),
    .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic apply_stimulus(input int p, input logic req, input logic wr, input logic [1:0] sz,
                                input logic [3:0] st, input logic [31:0] a, input logic [31:0] d);
    sram_req[p]          = req;
    sram_wr[p]           = wr;
    sram_size[2*p +: 2]  = sz;
    sram_wstrb[4*p +: 4] = st;
    sram_addr[32*p +: 32]  = a;
    sram_wdata[32*p +: 32] = d;
  endtask

  task automatic reset_slave();
    arready = 1'b0; rvalid = 1'b0; rid = '0; rdata = '0; rresp = '0; rlast = 1'b1;
    awready = 1'b0; wready = 1'b0; bvalid = 1'b0; bid = '0; bresp = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    resetn = 1'b0;
    sram_req = '0; sram_wr = '0; sram_size = '0; sram_wstrb = '0;
    sram_addr = '0; sram_wdata = '0;
    reset_slave();
    // In reset: requests and responses must not leak through.
    apply_stimulus(0, 1'b1, 1'b0, 2'd2, 4'hF, 32'h1C00_0000, 32'h0);
    rvalid = 1'b1;
    #3;
    check_output("rst_addr_ok", 32'(sram_addr_ok), 32'h0);
    check_output("rst_data_ok", 32'(sram_data_ok), 32'h0);
    check_output("rst_arvalid", 32'(arvalid), 32'h0);
    check_output("rst_awvalid", 32'(awvalid), 32'h0);
    check_output("rst_wvalid",  32'(wvalid),  32'h0);
    rvalid = 1'b0;
    sram_req = '0;
    @(posedge clk); @(posedge clk);
    @(negedge clk) resetn = 1'b1;
    tick();

    // Single read on port 0.
    apply_stimulus(0, 1'b1, 1'b0, 2'd2, 4'hF, 32'h1C00_0000, 32'h0);
    arready = 1'b1;
    #1 check_output("rd1_addr_ok", 32'(sram_addr_ok), 32'h1);
    tick();
    sram_req = '0;
    #1;
    check_output("rd1_arvalid", 32'(arvalid), 32'h1);
    check_output("rd1_araddr", araddr, 32'h1C00_0000);
    check_output("rd1_arid", 32'(arid), 32'h0);
    check_output("rd1_arsize", 32'(arsize), 32'h2);
    check_output("rd1_arlen", 32'(arlen), 32'h0);
    check_output("rd1_arburst", 32'(arburst), 32'h1);
    tick();
    rvalid = 1'b1; rid = 4'd0; rdata = 32'h1234_5678;
    #1;
    check_output("rd1_data_ok", 32'(sram_data_ok), 32'h1);
    check_output("rd1_rdata", sram_rdata[31:0], 32'h1234_5678);
    check_output("rd1_arvalid_done", 32'(arvalid), 32'h0);
    tick();
    rvalid = 1'b0;
    #1 check_output("rd1_data_ok_clr", 32'(sram_data_ok), 32'h0);

    // Both ports read every cycle; slave withholds responses until depth fills.
    apply_stimulus(0, 1'b1, 1'b0, 2'd2, 4'hF, 32'h0000_1000, 32'h0);
    apply_stimulus(1, 1'b1, 1'b0, 2'd2, 4'hF, 32'h0000_2000, 32'h0);
    rr_pattern = 20'b00_00_00_01_00_10_00_01_00_10;
    for (int i = 0; i < 10; i++) begin
      if (i > 0) tick();
      #1 check_output($sformatf("rr_addr_ok_c%0d", i), 32'(sram_addr_ok), 32'(rr_pattern[2*i +: 2]));
      if (i == 1) check_output("rr_arid_c1", 32'(arid), 32'h1);
      if (i == 3) check_output("rr_araddr_c3", araddr, 32'h0000_1000);
    end
    tick();
    rvalid = 1'b1; rid = 4'd1; rdata = 32'hAAAA_0001;
    #1;
    check_output("rr_data_ok1", 32'(sram_data_ok), 32'h2);
    check_output("rr_full_addr_ok", 32'(sram_addr_ok), 32'h0);
    tick();
    rvalid = 1'b0;
    #1 check_output("rr_regrant1", 32'(sram_addr_ok), 32'h2);
    tick();
    sram_req = '0;
    drain_ids = 4'b1100;
    for (int k = 0; k < 4; k++) begin
      tick();
      rvalid = 1'b1; rid = {3'b0, drain_ids[k]};
      #1 check_output($sformatf("rr_drain%0d", k), 32'(sram_data_ok), drain_ids[k] ? 32'h2 : 32'h1);
    end
    tick();
    rvalid = 1'b0;

    // Port 1 halfword write, awready late, wready immediate.
    apply_stimulus(1, 1'b1, 1'b1, 2'd1, 4'b0011, 32'h0000_01C0, 32'hDEAD_BEEF);
    wready = 1'b1;
    #1 check_output("wr_addr_ok", 32'(sram_addr_ok), 32'h2);
    tick();
    sram_req = '0;
    #1;
    check_output("wr_awvalid_c1", 32'(awvalid), 32'h1);
    check_output("wr_wvalid_c1", 32'(wvalid), 32'h1);
    check_output("wr_awsize", 32'(awsize), 32'h1);
    check_output("wr_awaddr", awaddr, 32'h0000_01C0);
    check_output("wr_wstrb", 32'(wstrb), 32'h3);
    check_output("wr_wdata", wdata, 32'hDEAD_BEEF);
    check_output("wr_awid", 32'(awid), 32'h1);
    check_output("wr_wid", 32'(wid), 32'h1);
    tick();
    #1;
    check_output("wr_wvalid_c2", 32'(wvalid), 32'h0);
    check_output("wr_awvalid_c2", 32'(awvalid), 32'h1);
    tick();
    #1 check_output("wr_awvalid_c3", 32'(awvalid), 32'h1);
    tick();
    awready = 1'b1;
    #1 check_output("wr_awvalid_c4", 32'(awvalid), 32'h1);
    tick();
    awready = 1'b0;
    #1;
    check_output("wr_awvalid_done", 32'(awvalid), 32'h0);
    check_output("wr_no_early_ok", 32'(sram_data_ok), 32'h0);
    tick();
    bvalid = 1'b1; bid = 4'd1;
    #1 check_output("wr_data_ok", 32'(sram_data_ok), 32'h2);
    tick();
    bvalid = 1'b0;
    #1 check_output("wr_data_ok_clr", 32'(sram_data_ok), 32'h0);

    // Read-after-write hazard against a pending write to 0x100.
    awready = 1'b1; wready = 1'b1;
    apply_stimulus(1, 1'b1, 1'b1, 2'd2, 4'hF, 32'h0000_0100, 32'h5555_AAAA);
    #1 check_output("raw_wr_addr_ok", 32'(sram_addr_ok), 32'h2);
    tick();
    sram_req[1] = 1'b0;
    apply_stimulus(0, 1'b1, 1'b0, 2'd2, 4'hF, 32'h0000_0100, 32'h0);
    #1 check_output("raw_send_block", 32'(sram_addr_ok), 32'h0);
    tick();
    #1 check_output("raw_resp_block", 32'(sram_addr_ok), 32'h0);
    tick();
    sram_addr[31:0] = 32'h0000_0104;
    #1 check_output("raw_other_word", 32'(sram_addr_ok), RAW_CMP ? 32'h1 : 32'h0);
    tick();
    sram_addr[31:0] = 32'h0000_0100;
    bvalid = 1'b1; bid = 4'd1;
    #1;
    check_output("raw_b_data_ok", 32'(sram_data_ok), 32'h2);
    check_output("raw_b_addr_ok", 32'(sram_addr_ok), 32'h0);
    tick();
    bvalid = 1'b0;
    #1 check_output("raw_released", 32'(sram_addr_ok), 32'h1);
    tick();
    sram_req = '0;
    #1;
    check_output("raw_arvalid", 32'(arvalid), 32'h1);
    check_output("raw_araddr", araddr, 32'h0000_0100);
    for (int k = 0; k < (RAW_CMP ? 2 : 1); k++) begin
      tick();
      rvalid = 1'b1; rid = 4'd0;
      #1 check_output($sformatf("raw_rd_ok%0d", k), 32'(sram_data_ok), 32'h1);
    end
    tick();
    rvalid = 1'b0;

    // Write from a port with a read in flight waits for that read to return.
    apply_stimulus(1, 1'b1, 1'b0, 2'd2, 4'hF, 32'h0000_0300, 32'h0);
    #1 check_output("ord_rd_addr_ok", 32'(sram_addr_ok), 32'h2);
    tick();
    apply_stimulus(1, 1'b1, 1'b1, 2'd2, 4'hF, 32'h0000_0304, 32'h0BAD_F00D);
    #1 check_output("ord_wr_block0", 32'(sram_addr_ok), 32'h0);
    tick();
    #1 check_output("ord_wr_block1", 32'(sram_addr_ok), 32'h0);
    tick();
    rvalid = 1'b1; rid = 4'd1; rdata = 32'h0000_0300;
    #1;
    check_output("ord_rd_data_ok", 32'(sram_data_ok), 32'h2);
    check_output("ord_wr_block2", 32'(sram_addr_ok), 32'h0);
    tick();
    rvalid = 1'b0;
    #1 check_output("ord_wr_grant", 32'(sram_addr_ok), 32'h2);
    tick();
    sram_req = '0;
    #1 check_output("ord_awaddr", awaddr, 32'h0000_0304);
    tick();
    bvalid = 1'b1; bid = 4'd1;
    #1 check_output("ord_wr_data_ok", 32'(sram_data_ok), 32'h2);
    tick();
    bvalid = 1'b0;

    // Reset while the AR channel is stalled.
    awready = 1'b0; wready = 1'b0; arready = 1'b0;
    apply_stimulus(0, 1'b1, 1'b0, 2'd2, 4'hF, 32'h1C00_0010, 32'h0);
    #1 check_output("mid_addr_ok", 32'(sram_addr_ok), 32'h1);
    tick();
    #1 check_output("mid_arvalid", 32'(arvalid), 32'h1);
    resetn = 1'b0;
    reset_slave();
    #1;
    check_output("mid_rst_arvalid", 32'(arvalid), 32'h0);
    check_output("mid_rst_addr_ok", 32'(sram_addr_ok), 32'h0);
    sram_req = '0;
    @(negedge clk) resetn = 1'b1;
    tick();
    apply_stimulus(0, 1'b1, 1'b0, 2'd2, 4'hF, 32'h1C00_0010, 32'h0);
    arready = 1'b1;
    #1 check_output("post_addr_ok", 32'(sram_addr_ok), 32'h1);
    tick();
    sram_req = '0;
    #1;
    check_output("post_arvalid", 32'(arvalid), 32'h1);
    check_output("post_araddr", araddr, 32'h1C00_0010);
    tick();
    rvalid = 1'b1; rid = 4'd0; rdata = 32'hCAFE_F00D;
    #1;
    check_output("post_data_ok", 32'(sram_data_ok), 32'h1);
    check_output("post_rdata", sram_rdata[31:0], 32'hCAFE_F00D);
    tick();
    rvalid = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
